// File: rtl/pcie_app_pkg.sv
// Shared constants and register decode for the pcie-dma application blocks.
package pcie_app_pkg;

    // Application register indices on the transceiver CPU register channel
    localparam int unsigned CONSUMER_RATE = 4;
    localparam int unsigned CHECKSUM_LSW  = 5;
    localparam int unsigned CHECKSUM_MSW  = 6;

    localparam int unsigned CHECKSUM_W = 64;
    localparam int unsigned RATE_RESET = 0;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RATE,
        SEL_LSW,
        SEL_MSW
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(input int unsigned idx);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (idx == CONSUMER_RATE)     sel = SEL_RATE;
        else if (idx == CHECKSUM_LSW) sel = SEL_LSW;
        else if (idx == CHECKSUM_MSW) sel = SEL_MSW;
        return sel;
    endfunction

endpackage

// File: rtl/pcie_app_throttle.sv
// Rate throttle: after each accepted word, holds ready low for 'rate' cycles.
module pcie_app_throttle #(
    parameter int unsigned RATE_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              accept,
    input  logic [RATE_W-1:0] rate,
    output logic              ready
);

    logic [RATE_W-1:0] count_q;

    // Countdown reloads on accept, otherwise drains towards zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= rate;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Ready depends on registered state and reset only, never on valid
    always_comb begin
        ready = rstn && (count_q == '0);
    end

endmodule

// File: rtl/pcie_app_consumer.sv
// C2F stream sink: throttled acceptance with a 64-bit running checksum,
// exposed through CONSUMER_RATE / CHECKSUM_LSW / CHECKSUM_MSW registers.
module pcie_app_consumer
    import pcie_app_pkg::*;
#(
    parameter int unsigned REG_AW = 6,
    parameter int unsigned RATE_W = 32
) (
    input  logic              pcieClk_in,
    input  logic              pcieRstn_in,
    input  logic [63:0]       c2fData_in,
    input  logic              c2fValid_in,
    output logic              c2fReady_out,
    input  logic [REG_AW-1:0] cpuWrAddr_in,
    input  logic [31:0]       cpuWrData_in,
    input  logic              cpuWrValid_in,
    input  logic [REG_AW-1:0] cpuRdAddr_in,
    output logic [31:0]       cpuRdData_out,
    output logic              cpuRdHit_out
);

    logic [RATE_W-1:0]     rate_q;
    logic [CHECKSUM_W-1:0] checksum_q;
    logic [CHECKSUM_W-1:0] checksum_d;
    logic [31:0]           msw_shadow_q;
    logic                  accept;
    logic                  wr_rate;
    logic                  wr_clear;
    reg_sel_e              wr_sel;
    reg_sel_e              rd_sel;

    // Write/read index decode and the handshake
    always_comb begin
        wr_sel   = reg_decode(32'(cpuWrAddr_in));
        rd_sel   = reg_decode(32'(cpuRdAddr_in));
        wr_rate  = cpuWrValid_in && (wr_sel == SEL_RATE);
        wr_clear = cpuWrValid_in && ((wr_sel == SEL_LSW) || (wr_sel == SEL_MSW));
        accept   = c2fValid_in && c2fReady_out;
    end

    pcie_app_throttle #(
        .RATE_W (RATE_W)
    ) u_throttle (
        .clk    (pcieClk_in),
        .rstn   (pcieRstn_in),
        .accept (accept),
        .rate   (rate_q),
        .ready  (c2fReady_out)
    );

    // Rate register; the throttle samples the pre-write value on a same-cycle accept
    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstn_in) begin
            rate_q <= RATE_W'(RATE_RESET);
        end else if (wr_rate) begin
            rate_q <= RATE_W'(cpuWrData_in);
        end
    end

    // Next checksum: a clear takes effect before a same-cycle accumulate
    always_comb begin
        checksum_d = wr_clear ? '0 : checksum_q;
        if (accept) begin
            checksum_d = checksum_d + c2fData_in;
        end
    end

    // Checksum state
    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstn_in) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    // Registered read port; an LSW read snapshots the upper half for a coherent MSW read
    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstn_in) begin
            cpuRdData_out <= '0;
            cpuRdHit_out  <= 1'b0;
            msw_shadow_q  <= '0;
        end else begin
            cpuRdData_out <= '0;
            cpuRdHit_out  <= 1'b0;
            case (rd_sel)
                SEL_RATE: begin
                    cpuRdData_out <= 32'(rate_q);
                    cpuRdHit_out  <= 1'b1;
                end
                SEL_LSW: begin
                    cpuRdData_out <= checksum_q[31:0];
                    cpuRdHit_out  <= 1'b1;
                    msw_shadow_q  <= checksum_q[63:32];
                end
                SEL_MSW: begin
                    cpuRdData_out <= msw_shadow_q;
                    cpuRdHit_out  <= 1'b1;
                end
                default: begin
                    cpuRdData_out <= '0;
                    cpuRdHit_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_app_consumer.sv
// Directed bench for pcie_app_consumer: throttle spacing, checksum wrap,
// MSW shadow coherence, clear/accept overlap and mid-stream reset.
module tb_pcie_app_consumer;
    import pcie_app_pkg::*;

    localparam logic [5:0] UNMAPPED = 6'h3F;
    localparam logic [5:0] A_RATE   = 6'(CONSUMER_RATE);
    localparam logic [5:0] A_LSW    = 6'(CHECKSUM_LSW);
    localparam logic [5:0] A_MSW    = 6'(CHECKSUM_MSW);

    logic        clk;
    logic        rstn;
    logic [63:0] c2f_data;
    logic        c2f_valid;
    logic        c2f_ready;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;

    int unsigned pass_cnt;
    int unsigned chk_cnt;
    int unsigned fail_cnt;

    pcie_app_consumer #(
        .REG_AW (6),
        .RATE_W (32)
    ) dut (
        .pcieClk_in    (clk),
        .pcieRstn_in   (rstn),
        .c2fData_in    (c2f_data),
        .c2fValid_in   (c2f_valid),
        .c2fReady_out  (c2f_ready),
        .cpuWrAddr_in  (wr_addr),
        .cpuWrData_in  (wr_data),
        .cpuWrValid_in (wr_valid),
        .cpuRdAddr_in  (rd_addr),
        .cpuRdData_out (rd_data),
        .cpuRdHit_out  (rd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a,
                          input logic [31:0] exp_d, input logic exp_hit);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk({tag, "_data"}, 64'(rd_data), 64'(exp_d));
        chk({tag, "_hit"}, 64'(rd_hit), 64'(exp_hit));
        rd_addr = UNMAPPED;
    endtask

    task automatic send1(input string tag, input logic [63:0] d);
        @(negedge clk);
        c2f_valid = 1'b1;
        c2f_data  = d;
        #1 chk({tag, "_ready"}, 64'(c2f_ready), 64'd1);
        @(negedge clk);
        c2f_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        chk_cnt   = 0;
        fail_cnt  = 0;
        rstn      = 1'b0;
        c2f_data  = '0;
        c2f_valid = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_addr   = A_LSW;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(c2f_ready), 64'd0);
        chk("rst_rddata", 64'(rd_data), 64'd0);
        chk("rst_rdhit", 64'(rd_hit), 64'd0);
        @(negedge clk);
        rstn    = 1'b1;
        rd_addr = UNMAPPED;
        #1 chk("post_rst_ready", 64'(c2f_ready), 64'd1);

        // Rate 0: four back-to-back words 1..4
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c2f_valid = 1'b1;
            c2f_data  = 64'(i + 1);
            #1 chk("r0_ready", 64'(c2f_ready), 64'd1);
        end
        @(negedge clk);
        c2f_valid = 1'b0;
        rd_chk("r0_lsw", A_LSW, 32'd10, 1'b1);
        rd_chk("r0_msw", A_MSW, 32'd0, 1'b1);

        // Rate 3: three words of 5, accepts every 4th cycle
        reg_wr(A_LSW, 32'd0);
        reg_wr(A_RATE, 32'd3);
        rd_chk("rate3_rd", A_RATE, 32'd3, 1'b1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            c2f_valid = 1'b1;
            c2f_data  = 64'd5;
            #1 chk("r3_ready", 64'(c2f_ready), ((c % 4) == 0) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        c2f_valid = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("r3_lsw", A_LSW, 32'd15, 1'b1);
        reg_wr(A_RATE, 32'd0);

        // Wrap: all-ones + 2 = 1, carry out of bit 63 discarded
        reg_wr(A_MSW, 32'd0);
        send1("wrap_a", 64'hFFFF_FFFF_FFFF_FFFF);
        send1("wrap_b", 64'h2);
        rd_chk("wrap_lsw", A_LSW, 32'h1, 1'b1);
        rd_chk("wrap_msw", A_MSW, 32'h0, 1'b1);

        // Shadow: MSW read returns the value latched at the last LSW read
        reg_wr(A_LSW, 32'd0);
        send1("sh_a", 64'h1_0000_0005);
        rd_chk("sh_lsw1", A_LSW, 32'h5, 1'b1);
        send1("sh_b", 64'h1_0000_0000);
        rd_chk("sh_msw_stale", A_MSW, 32'h1, 1'b1);
        rd_chk("sh_lsw2", A_LSW, 32'h5, 1'b1);
        rd_chk("sh_msw_fresh", A_MSW, 32'h2, 1'b1);

        // Clear and accept 7 in the same cycle on a nonzero checksum
        @(negedge clk);
        c2f_valid = 1'b1;
        c2f_data  = 64'h7;
        wr_addr   = A_LSW;
        wr_data   = 32'd0;
        wr_valid  = 1'b1;
        @(negedge clk);
        c2f_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_chk("clracc_lsw", A_LSW, 32'h7, 1'b1);
        rd_chk("clracc_msw", A_MSW, 32'h0, 1'b1);

        // Rate 2, rewrite to 5 mid-countdown: accepts at c=0, 3, 9
        reg_wr(A_RATE, 32'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            c2f_valid = 1'b1;
            c2f_data  = 64'd1;
            if (c == 1) begin
                wr_addr  = A_RATE;
                wr_data  = 32'd5;
                wr_valid = 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
            #1 chk("r25_ready", 64'(c2f_ready),
                   (c == 0 || c == 3 || c == 9) ? 64'd1 : 64'd0);
        end

        // Reset mid-countdown with valid still high; nothing may be accepted
        @(negedge clk);
        c2f_data = 64'h99;
        rstn     = 1'b0;
        rd_addr  = A_LSW;
        #1 chk("mrst_ready0", 64'(c2f_ready), 64'd0);
        @(negedge clk);
        #1 chk("mrst_ready1", 64'(c2f_ready), 64'd0);
        chk("mrst_rddata", 64'(rd_data), 64'd0);
        chk("mrst_rdhit", 64'(rd_hit), 64'd0);
        @(negedge clk);
        rstn      = 1'b1;
        c2f_valid = 1'b0;
        rd_addr   = UNMAPPED;
        #1 chk("mrst_ready_rel", 64'(c2f_ready), 64'd1);
        rd_chk("mrst_rate", A_RATE, 32'd0, 1'b1);
        rd_chk("mrst_lsw", A_LSW, 32'd0, 1'b1);
        rd_chk("mrst_msw", A_MSW, 32'd0, 1'b1);
        rd_chk("unmapped", UNMAPPED, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
